axi4_ram_slave: RTL and testbench
=================================

Name: axi4_ram_slave

Overview:
- AXI4 slave word-addressed RAM; sits directly downstream of the UART-to-AXI4 command bridge and answers its AW/W/B/AR/R bursts.
- Gives the UART debug path a bring-up target; later replaced by real peripherals on the same port subset.
- One outstanding transaction at a time; INCR bursts only, 1 to 256 beats.

Parameters:
- BYTE_WIDTH, 2, data width in bytes; wdata/rdata are 8*BYTE_WIDTH bits.
- A_WIDTH, 32, address width in bits.
- DEPTH_AW, 8, RAM depth is 2**DEPTH_AW words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- awvalid  in  1  / awready  out  1  / awaddr  in  A_WIDTH  / awlen  in  8  write address channel.
- wvalid  in  1  / wready  out  1  / wlast  in  1  / wdata  in  8*BYTE_WIDTH  write data channel.
- bvalid  out  1  / bready  in  1  / bresp  out  2  write response channel.
- arvalid  in  1  / arready  out  1  / araddr  in  A_WIDTH  / arlen  in  8  read address channel.
- rvalid  out  1  / rready  in  1  / rlast  out  1  / rdata  out  8*BYTE_WIDTH  / rresp  out  2  read data channel.

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low, named clk and rstn.
- Addressing: awaddr/araddr are word addresses; each beat increments the address by 1.
- States: IDLE, WDATA, WRESP, RDATA. Reset value is IDLE with every output 0. RAM contents are not reset.
- awready = (state==IDLE). arready = (state==IDLE) && !awvalid, so writes win when AW and AR are valid in the same cycle.
- AW handshake:
  - Latch start address and len.
  - err_dec is set if the address bits above DEPTH_AW are nonzero, or if start + len > 2**DEPTH_AW - 1 (the burst would wrap). No wrap is performed.
  - Beat counter is cleared. Go to WDATA.
- WDATA:
  - wready = 1.
  - Each wvalid&&wready beat writes wdata to RAM[addr+beat], but only if !err_dec and beat <= len.
  - Beats with beat > len are discarded.
  - err_slv is set if wlast arrives on a beat != len, or if no wlast has arrived by beat len (the burst continues until wlast).
  - The beat carrying wlast moves the state to WRESP.
- WRESP:
  - bvalid = 1; bresp = 2'b11 if err_dec, else 2'b10 if err_slv, else 2'b00.
  - Hold until bready; on bvalid&&bready go to IDLE, clear errors.
- AR handshake: latch address, len and err_dec (same rule as writes). Start RAM read of the first word. Go to RDATA.
- RDATA:
  - rvalid rises exactly 2 cycles after the AR handshake cycle.
  - rdata = RAM word, or 0 if err_dec. rresp = 2'b11 if err_dec, else 2'b00.
  - rlast = (beat == len).
  - With rready held high, beats are back-to-back, one per cycle.
  - When rready is low, rvalid/rdata/rlast/rresp stay stable. Use a skid register so no beat is lost or repeated.
  - The rlast handshake returns to IDLE; the next AW/AR can be accepted the following cycle.
- Length: len is 8 bits; awlen=255 gives a 256-beat burst. The beat counter is 9 bits so it does not roll over.
- Reset mid-burst: returns to IDLE at once with all valids/readies low. Partially written RAM words keep their values; no response is issued.
- Throughput: write beats run one per cycle. Write burst latency is AW handshake + (len+1) beats + 1 cycle to bvalid.

Test Plan:
- Single write then read:
  - AW addr=0x10 len=0, W 0xBEEF with wlast -> bvalid after 1 cycle, bresp=00.
  - AR addr=0x10 len=0 -> rvalid 2 cycles later, rdata=0xBEEF, rlast=1, rresp=00.
- 4-beat burst with backpressure:
  - Write 0x0001..0x0004 at addr 0x20 len=3.
  - Read back with rready toggling 1,0,0,1,... -> 4 beats in order, rlast only on the 4th, data stable while rready=0.
- Decode error:
  - AW addr=0x100 len=0 (DEPTH_AW=8) -> bresp=11 and RAM unchanged.
  - AR addr=0xFE len=3 -> 4 beats rdata=0, rresp=11.
- wlast mismatch:
  - AW len=3 with wlast on beat 1 -> only 2 words written, bresp=10.
  - AW len=0 with wlast on beat 2 -> only 1 word written, bresp=10.
- Simultaneous AW/AR in IDLE -> awready=1, arready=0. After the write response completes, AR is accepted and returns the newly written data.
- Assert rstn low mid 8-beat read -> rvalid=0 immediately. After release, a new read of the same range returns the original contents.

Source files
------------

// File: rtl/axi4_ram_slave.sv
// Word-addressed AXI4 slave RAM: one outstanding INCR burst (1..256 beats), with decode and
// wlast checking. The read side is a two-stage pipeline (RAM register, then output register).
module axi4_ram_slave #(
    parameter int unsigned BYTE_WIDTH = 2,
    parameter int unsigned A_WIDTH    = 32,
    parameter int unsigned DEPTH_AW   = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [A_WIDTH-1:0]      awaddr,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    wlast,
    input  logic [8*BYTE_WIDTH-1:0] wdata,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [A_WIDTH-1:0]      araddr,
    input  logic [7:0]              arlen,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    rlast,
    output logic [8*BYTE_WIDTH-1:0] rdata,
    output logic [1:0]              rresp
);
    localparam int unsigned DW    = 8 * BYTE_WIDTH;
    localparam int unsigned Words = 2 ** DEPTH_AW;
    localparam int unsigned SumW  = ((DEPTH_AW > 8) ? DEPTH_AW : 8) + 1;

    typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_AW-1:0]   addr_q;
    logic [7:0]            len_q;
    logic [8:0]            beat_q;
    logic                  err_dec_q, err_slv_q;
    logic                  s1_valid_q, s1_last_q;
    logic [DW-1:0]         s1_data_q;
    logic                  rvalid_q, rlast_q;
    logic [DW-1:0]         rdata_q;
    logic [DW-1:0]         mem [Words];

    logic                  aw_hs, ar_hs, w_beat, b_hs;
    logic                  out_load, s1_to_out, s1_free, rd_issue;
    logic [8:0]            len9;
    logic [DEPTH_AW-1:0]   beat_idx, rd_idx;

    // Out of range high bits, or a burst that would run past the last word.
    function automatic logic decode_err(input logic [A_WIDTH-1:0] a, input logic [7:0] l);
        logic [SumW-1:0] sum;
        sum = SumW'(a[DEPTH_AW-1:0]) + SumW'(l);
        return ((a >> DEPTH_AW) != '0) || (sum > SumW'(Words - 1));
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (state_q)
            StIdle: begin
                awready = rstn;
                arready = rstn && !awvalid;
                if (awvalid && rstn) begin
                    state_d = StWdata;
                end else if (arvalid && rstn) begin
                    state_d = StRdata;
                end
            end
            StWdata: begin
                wready = 1'b1;
                if (wvalid && wlast) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = StIdle;
                end
            end
            StRdata: begin
                if (rvalid_q && rready && rlast_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign aw_hs    = awvalid && awready;
    assign ar_hs    = arvalid && arready;
    assign w_beat   = wvalid && wready;
    assign b_hs     = bvalid && bready;
    assign len9     = {1'b0, len_q};
    assign beat_idx = addr_q + DEPTH_AW'(beat_q);

    // The RAM stage only advances when the output register can take its word, so a stalled
    // beat is parked there instead of being dropped.
    assign out_load  = !rvalid_q || rready;
    assign s1_to_out = s1_valid_q && out_load;
    assign s1_free   = !s1_valid_q || out_load;
    assign rd_issue  = ar_hs || ((state_q == StRdata) && (beat_q <= len9) && s1_free);
    assign rd_idx    = ar_hs ? araddr[DEPTH_AW-1:0] : beat_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            err_dec_q  <= 1'b0;
            err_slv_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (aw_hs) begin
                addr_q    <= awaddr[DEPTH_AW-1:0];
                len_q     <= awlen;
                err_dec_q <= decode_err(awaddr, awlen);
                err_slv_q <= 1'b0;
                beat_q    <= '0;
            end
            if (ar_hs) begin
                addr_q    <= araddr[DEPTH_AW-1:0];
                len_q     <= arlen;
                err_dec_q <= decode_err(araddr, arlen);
                err_slv_q <= 1'b0;
                beat_q    <= 9'd1;
            end
            if (w_beat) begin
                if ((wlast && (beat_q != len9)) || (!wlast && (beat_q == len9))) begin
                    err_slv_q <= 1'b1;
                end
                if (beat_q != '1) begin
                    beat_q <= beat_q + 9'd1;
                end
            end
            if (b_hs) begin
                err_dec_q <= 1'b0;
                err_slv_q <= 1'b0;
            end
            if (rd_issue && !ar_hs) begin
                beat_q <= beat_q + 9'd1;
            end
            if (rd_issue) begin
                s1_valid_q <= 1'b1;
                s1_last_q  <= ar_hs ? (arlen == 8'd0) : (beat_q == len9);
            end else if (s1_to_out) begin
                s1_valid_q <= 1'b0;
            end
            if (out_load) begin
                rvalid_q <= s1_valid_q;
                rlast_q  <= s1_last_q;
                rdata_q  <= s1_data_q;
            end
        end
    end

    // RAM array and its read register carry no reset.
    always_ff @(posedge clk) begin
        if (w_beat && !err_dec_q && (beat_q <= len9)) begin
            mem[beat_idx] <= wdata;
        end
        if (rd_issue) begin
            s1_data_q <= mem[rd_idx];
        end
    end

    assign rvalid = rvalid_q;
    assign rlast  = rvalid_q && rlast_q;
    assign rdata  = (rvalid_q && !err_dec_q) ? rdata_q : '0;
    assign rresp  = (rvalid_q && err_dec_q) ? 2'b11 : 2'b00;
    assign bresp  = !bvalid ? 2'b00 : err_dec_q ? 2'b11 : err_slv_q ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave: stimulus pushes expected B/R responses into queues,
// and a negedge monitor pops and compares them as the DUT hands them out.
module tb_axi4_ram_slave;
    localparam int DW  = 16;
    localparam int TMO = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic [1:0]    resp;
    } rbeat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    bresp, rresp;

    int checks = 0;
    int errors = 0;
    int r_got  = 0;

    logic [1:0] exp_b[$];
    rbeat_t     exp_r[$];

    axi4_ram_slave dut (
        .clk     (clk),
        .rstn    (rstn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .wvalid  (wvalid),
        .wready  (wready),
        .wlast   (wlast),
        .wdata   (wdata),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .rvalid  (rvalid),
        .rready  (rready),
        .rlast   (rlast),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, TMO, $time);
    endtask

    task automatic push_r(input logic [DW-1:0] d, input logic l, input logic [1:0] r);
        rbeat_t e;
        e.d    = d;
        e.last = l;
        e.resp = r;
        exp_r.push_back(e);
    endtask

    // Burst of nbeats with wlast on the final one; data is base, base+1, ...
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                            input logic [DW-1:0] base, input logic [1:0] resp);
        int n;
        exp_b.push_back(resp);
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        n = 0;
        @(negedge clk);
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (n >= TMO) begin timeout("aw_wait"); return; end
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1;
            wdata  = base + 16'(i);
            wlast  = (i == nbeats - 1);
            n = 0;
            @(negedge clk);
            while (!wready && n < TMO) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            if (n >= TMO) begin
                wvalid = 1'b0;
                wlast  = 1'b0;
                timeout("w_wait");
                return;
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        check("b_latency", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    // Expected beats must already be queued; toggle gives rready = 1,0,0,1,0,0,...
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input bit toggle);
        int n;
        int target;
        target  = r_got + nbeats;
        arvalid = 1'b1;
        araddr  = addr;
        arlen   = len;
        rready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (n >= TMO) begin timeout("ar_wait"); return; end
        for (int k = 0; k < TMO + 3 * nbeats; k++) begin
            rready = toggle ? (k % 3 == 0) : 1'b1;
            @(negedge clk);
            if (k == 0) check("r_lat_early", 32'(rvalid), 32'd0);
            if (k == 1) check("r_lat", 32'(rvalid), 32'd1);
            @(posedge clk); #1;
            if (r_got >= target) break;
        end
        rready = 1'b1;
        if (r_got < target) timeout("r_beats");
    endtask

    initial begin : monitor
        rbeat_t        e;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [1:0]    prev_resp;
        logic [1:0]    eb;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        prev_resp  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("r_stable_valid", 32'(rvalid), 32'd1);
                    check("r_stable_data", 32'({rdata, rlast, rresp}),
                          32'({prev_data, prev_last, prev_resp}));
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        timeout("b_unexpected");
                    end else begin
                        eb = exp_b.pop_front();
                        check("bresp", 32'(bresp), 32'(eb));
                    end
                end
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) begin
                        timeout("r_unexpected");
                    end else begin
                        e = exp_r.pop_front();
                        check("rdata", 32'(rdata), 32'(e.d));
                        check("rlast", 32'(rlast), 32'(e.last));
                        check("rresp", 32'(rresp), 32'(e.resp));
                    end
                    r_got++;
                end
                prev_stall = rvalid && !rready;
                prev_data  = rdata;
                prev_last  = rlast;
                prev_resp  = rresp;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int target;
        rstn    = 1'b0;
        awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid  = 1'b0; wlast  = 1'b0; wdata = '0;
        arvalid = 1'b0; araddr = '0; arlen = '0;
        bready  = 1'b1;
        rready  = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_readies", 32'({awready, arready, wready}), 32'd0);
        check("rst_valids", 32'({bvalid, rvalid, rlast}), 32'd0);
        check("rst_data", 32'({rdata, bresp, rresp}), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;

        // Single write then read.
        do_write(32'h10, 8'd0, 1, 16'hBEEF, 2'b00);
        push_r(16'hBEEF, 1'b1, 2'b00);
        do_read(32'h10, 8'd0, 1, 1'b0);

        // 4-beat burst, read back under rready backpressure.
        do_write(32'h20, 8'd3, 4, 16'h0001, 2'b00);
        for (int i = 0; i < 4; i++) push_r(16'h0001 + 16'(i), i == 3, 2'b00);
        do_read(32'h20, 8'd3, 4, 1'b1);

        // Decode errors: 0x100 aliases word 0, which must keep its value.
        do_write(32'h00, 8'd0, 1, 16'h0A0A, 2'b00);
        do_write(32'h100, 8'd0, 1, 16'hDEAD, 2'b11);
        push_r(16'h0A0A, 1'b1, 2'b00);
        do_read(32'h00, 8'd0, 1, 1'b0);
        for (int i = 0; i < 4; i++) push_r(16'h0000, i == 3, 2'b11);
        do_read(32'hFE, 8'd3, 4, 1'b0);

        // Early wlast: only beats 0 and 1 land.
        do_write(32'h30, 8'd3, 4, 16'hA000, 2'b00);
        do_write(32'h30, 8'd3, 2, 16'h3000, 2'b10);
        push_r(16'h3000, 1'b0, 2'b00);
        push_r(16'h3001, 1'b0, 2'b00);
        push_r(16'hA002, 1'b0, 2'b00);
        push_r(16'hA003, 1'b1, 2'b00);
        do_read(32'h30, 8'd3, 4, 1'b0);

        // Late wlast: beats past len are discarded.
        do_write(32'h38, 8'd2, 3, 16'hB000, 2'b00);
        do_write(32'h38, 8'd0, 3, 16'h3800, 2'b10);
        push_r(16'h3800, 1'b0, 2'b00);
        push_r(16'hB001, 1'b0, 2'b00);
        push_r(16'hB002, 1'b1, 2'b00);
        do_read(32'h38, 8'd2, 3, 1'b0);

        // Simultaneous AW and AR: write wins, read then sees the new word.
        exp_b.push_back(2'b00);
        push_r(16'h5555, 1'b1, 2'b00);
        target  = r_got + 1;
        awvalid = 1'b1; awaddr = 32'h50; awlen = 8'd0;
        arvalid = 1'b1; araddr = 32'h50; arlen = 8'd0;
        @(negedge clk);
        check("sim_awready", 32'(awready), 32'd1);
        check("sim_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b1; wdata = 16'h5555; wlast = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (n >= TMO) timeout("sim_ar");
        n = 0;
        while (r_got < target && n < TMO) begin @(posedge clk); #1; n++; end
        if (r_got < target) timeout("sim_r");

        // Reset in the middle of an 8-beat read.
        do_write(32'h40, 8'd7, 8, 16'h4000, 2'b00);
        for (int i = 0; i < 8; i++) push_r(16'h4000 + 16'(i), i == 7, 2'b00);
        target  = r_got + 3;
        arvalid = 1'b1; araddr = 32'h40; arlen = 8'd7;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (r_got < target && n < TMO) begin @(posedge clk); #1; n++; end
        if (r_got < target) timeout("rst_mid_r");
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_readies", 32'({awready, arready}), 32'd0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push_r(16'h4000 + 16'(i), i == 7, 2'b00);
        do_read(32'h40, 8'd7, 8, 1'b0);

        // Longest legal burst, then the same length one word higher (would wrap).
        do_write(32'h00, 8'd255, 256, 16'hC000, 2'b00);
        for (int i = 0; i < 256; i++) push_r(16'hC000 + 16'(i), i == 255, 2'b00);
        do_read(32'h00, 8'd255, 256, 1'b0);
        do_write(32'h01, 8'd255, 256, 16'h1111, 2'b11);

        repeat (4) @(posedge clk);
        check("exp_b_empty", 32'(exp_b.size()), 32'd0);
        check("exp_r_empty", 32'(exp_r.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
